// File: rtl/regfile_responder.sv
// Register-file responder on the bus_if transaction bus: selector latching, write,
// two read ports and a multi-cycle CLEAR, with a registered one-cycle response strobe.
module regfile_responder #(
  parameter int unsigned NUM_REGS = 8,
  parameter bit          ZERO_REG = 1'b1,
  parameter type         word_t   = logic [31:0]
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  word_t      i_data,
  input  logic       i_valid,
  input  logic [3:0] i_command,
  output word_t      o_data,
  output logic       o_valid,
  output logic [3:0] o_error
);

  localparam int unsigned IW = $clog2(NUM_REGS);

  localparam logic [3:0] CMD_NOP    = 4'h0;
  localparam logic [3:0] CMD_SEL_A  = 4'h1;
  localparam logic [3:0] CMD_SEL_B  = 4'h2;
  localparam logic [3:0] CMD_SEL_W  = 4'h3;
  localparam logic [3:0] CMD_WRITE  = 4'h4;
  localparam logic [3:0] CMD_READ_A = 4'h5;
  localparam logic [3:0] CMD_READ_B = 4'h6;
  localparam logic [3:0] CMD_CLEAR  = 4'h7;

  localparam logic [3:0] ERR_OK        = 4'd0;
  localparam logic [3:0] ERR_BAD_CMD   = 4'd1;
  localparam logic [3:0] ERR_BAD_INDEX = 4'd2;
  localparam logic [3:0] ERR_BUSY      = 4'd3;
  localparam logic [3:0] ERR_READ_ONLY = 4'd4;

  typedef enum logic {S_IDLE, S_CLEAR} state_t;
  typedef logic [IW-1:0] idx_t;

  state_t     r_state, w_state_nxt;
  idx_t       r_cnt, w_cnt_nxt;
  idx_t       r_sel_a, r_sel_b, r_sel_w;
  idx_t       w_sel_a_nxt, w_sel_b_nxt, w_sel_w_nxt;
  word_t      r_regs [NUM_REGS];
  word_t      r_data, w_data_nxt;
  logic       r_valid, w_valid_nxt;
  logic [3:0] r_error, w_error_nxt;
  logic       w_we, w_clr, w_bad_idx;
  word_t      w_rd_a, w_rd_b;

  assign o_data  = r_data;
  assign o_valid = r_valid;
  assign o_error = r_error;

  // Register 0 reads as zero when it is the hardwired zero register.
  always_comb begin
    w_rd_a = r_regs[r_sel_a];
    w_rd_b = r_regs[r_sel_b];
    if (ZERO_REG && (r_sel_a == '0)) w_rd_a = '0;
    if (ZERO_REG && (r_sel_b == '0)) w_rd_b = '0;
  end

  assign w_bad_idx = ((i_data >> IW) != '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_sel_a <= '0;
      r_sel_b <= '0;
      r_sel_w <= '0;
      r_data  <= '0;
      r_valid <= 1'b0;
      r_error <= ERR_OK;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_sel_a <= w_sel_a_nxt;
      r_sel_b <= w_sel_b_nxt;
      r_sel_w <= w_sel_w_nxt;
      r_data  <= w_data_nxt;
      r_valid <= w_valid_nxt;
      r_error <= w_error_nxt;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < int'(NUM_REGS); i++) r_regs[i] <= '0;
    end else if (w_clr) begin
      r_regs[r_cnt] <= '0;
    end else if (w_we) begin
      r_regs[r_sel_w] <= i_data;
    end
  end

  // Next-state and response decode.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_sel_a_nxt = r_sel_a;
    w_sel_b_nxt = r_sel_b;
    w_sel_w_nxt = r_sel_w;
    w_data_nxt  = r_data;
    w_valid_nxt = 1'b0;
    w_error_nxt = r_error;
    w_we        = 1'b0;
    w_clr       = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_valid && (i_command != CMD_NOP)) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = '0;
          w_error_nxt = ERR_OK;
          case (i_command)
            CMD_SEL_A, CMD_SEL_B, CMD_SEL_W: begin
              if (w_bad_idx) begin
                w_error_nxt = ERR_BAD_INDEX;
              end else if (i_command == CMD_SEL_A) begin
                w_sel_a_nxt = i_data[IW-1:0];
              end else if (i_command == CMD_SEL_B) begin
                w_sel_b_nxt = i_data[IW-1:0];
              end else begin
                w_sel_w_nxt = i_data[IW-1:0];
              end
            end
            CMD_WRITE: begin
              if (ZERO_REG && (r_sel_w == '0)) w_error_nxt = ERR_READ_ONLY;
              else                             w_we        = 1'b1;
            end
            CMD_READ_A: w_data_nxt = w_rd_a;
            CMD_READ_B: w_data_nxt = w_rd_b;
            CMD_CLEAR: begin
              w_valid_nxt = 1'b0;
              w_data_nxt  = r_data;
              w_error_nxt = r_error;
              w_state_nxt = S_CLEAR;
              w_cnt_nxt   = '0;
            end
            default: w_error_nxt = ERR_BAD_CMD;
          endcase
        end
      end
      S_CLEAR: begin
        w_clr     = 1'b1;
        w_cnt_nxt = r_cnt + IW'(1);
        // Completion response wins over any command presented on the last edge.
        if (r_cnt == IW'(NUM_REGS - 1)) begin
          w_state_nxt = S_IDLE;
          w_cnt_nxt   = '0;
          w_valid_nxt = 1'b1;
          w_data_nxt  = '0;
          w_error_nxt = ERR_OK;
        end else if (i_valid && (i_command != CMD_NOP)) begin
          w_valid_nxt = 1'b1;
          w_data_nxt  = '0;
          w_error_nxt = ERR_BUSY;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_regfile_responder.sv
// Directed bench for regfile_responder: each step drives one cycle and checks the
// registered response one time unit after the sampling edge.
module tb_regfile_responder;

  logic        i_clk;
  logic        i_rst_n;
  logic [31:0] i_data;
  logic        i_valid;
  logic [3:0]  i_command;
  logic [31:0] o_data;
  logic        o_valid;
  logic [3:0]  o_error;

  int checks;
  int failures;

  regfile_responder dut (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_data    (i_data),
    .i_valid   (i_valid),
    .i_command (i_command),
    .o_data    (o_data),
    .o_valid   (o_valid),
    .o_error   (o_error)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Present one command for exactly one edge, then sample just after that edge.
  task automatic issue(input logic [3:0] cmd, input logic [31:0] data);
    i_valid   = 1'b1;
    i_command = cmd;
    i_data    = data;
    @(posedge i_clk);
    #1;
    i_valid   = 1'b0;
    i_command = 4'h0;
    i_data    = 32'h0;
  endtask

  task automatic idle();
    @(posedge i_clk);
    #1;
  endtask

  task automatic resp(input string tag, input logic [31:0] d, input logic [3:0] e);
    chk({tag, ".valid"}, 32'(o_valid), 32'd1);
    chk({tag, ".data"},  o_data, d);
    chk({tag, ".error"}, 32'(o_error), 32'(e));
  endtask

  initial begin
    checks    = 0;
    failures  = 0;
    i_rst_n   = 1'b0;
    i_valid   = 1'b0;
    i_command = 4'h0;
    i_data    = 32'h0;
    #23;
    chk("reset.valid", 32'(o_valid), 32'd0);
    chk("reset.data",  o_data, 32'd0);
    chk("reset.error", 32'(o_error), 32'd0);
    @(negedge i_clk);
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;

    // Back-to-back select/write/select/read.
    issue(4'h3, 32'd3);         resp("selw3", 32'h0, 4'd0);
    issue(4'h4, 32'hBEEF);      resp("write_beef", 32'h0, 4'd0);
    issue(4'h1, 32'd3);         resp("sela3", 32'h0, 4'd0);
    issue(4'h5, 32'h0);         resp("reada_beef", 32'hBEEF, 4'd0);
    idle();
    chk("hold.valid", 32'(o_valid), 32'd0);
    chk("hold.data",  o_data, 32'hBEEF);

    // Zero register is write-protected and reads as zero.
    issue(4'h3, 32'd0);         resp("selw0", 32'h0, 4'd0);
    issue(4'h4, 32'h1234);      resp("write_r0", 32'h0, 4'd4);
    issue(4'h1, 32'd0);         resp("sela0", 32'h0, 4'd0);
    issue(4'h5, 32'h0);         resp("reada_r0", 32'h0, 4'd0);

    // Out-of-range selector leaves the old selection in place.
    issue(4'h2, 32'd3);         resp("selb3", 32'h0, 4'd0);
    issue(4'h2, 32'd8);         resp("selb_bad", 32'h0, 4'd2);
    issue(4'h6, 32'h0);         resp("readb_kept", 32'hBEEF, 4'd0);
    issue(4'h2, 32'h8000_0001); resp("selb_hibit", 32'h0, 4'd2);

    // Illegal command and NOP.
    issue(4'hA, 32'd5);         resp("badcmd", 32'h0, 4'd1);
    issue(4'h0, 32'd1);
    chk("nop.valid", 32'(o_valid), 32'd0);
    chk("nop.error_held", 32'(o_error), 32'd1);
    issue(4'h6, 32'h0);         resp("readb_after_bad", 32'hBEEF, 4'd0);
    i_data = 32'd7; i_command = 4'h1;
    idle();
    chk("novalid.ignored", 32'(o_valid), 32'd0);
    issue(4'h5, 32'h0);         resp("reada_sel_unchanged", 32'h0, 4'd0);

    // Fill 1..7, then CLEAR with reads on E1 and E_N.
    for (int i = 1; i < 8; i++) begin
      issue(4'h3, 32'(i));
      issue(4'h4, 32'h1000 + 32'(i));
    end
    issue(4'h1, 32'd5);
    issue(4'h5, 32'h0);         resp("fill_r5", 32'h1005, 4'd0);
    issue(4'h7, 32'h0);
    chk("clear_e0.valid", 32'(o_valid), 32'd0);
    issue(4'h5, 32'h0);         resp("clear_e1_busy", 32'h0, 4'd3);
    for (int e = 2; e < 8; e++) begin
      idle();
      chk($sformatf("clear_e%0d.valid", e), 32'(o_valid), 32'd0);
    end
    issue(4'h5, 32'h0);         resp("clear_done", 32'h0, 4'd0);
    idle();
    chk("clear_done.pulse", 32'(o_valid), 32'd0);
    issue(4'h6, 32'h0);         resp("clear_readb_r3", 32'h0, 4'd0);
    for (int i = 1; i < 8; i++) begin
      issue(4'h1, 32'(i));
      issue(4'h5, 32'h0);
      resp($sformatf("cleared_r%0d", i), 32'h0, 4'd0);
    end

    // Asynchronous reset in the middle of CLEAR.
    issue(4'h3, 32'd2);
    issue(4'h4, 32'h55);
    issue(4'h1, 32'd2);
    issue(4'h5, 32'h0);         resp("pre_rst_r2", 32'h55, 4'd0);
    issue(4'h7, 32'h0);
    idle();
    idle();
    issue(4'h6, 32'h0);         resp("rst_e3_busy", 32'h0, 4'd3);
    #2;
    i_rst_n = 1'b0;
    #1;
    chk("midrst.valid", 32'(o_valid), 32'd0);
    chk("midrst.error", 32'(o_error), 32'd0);
    chk("midrst.data",  o_data, 32'd0);
    #13;
    i_rst_n = 1'b1;
    @(posedge i_clk);
    #1;
    issue(4'h5, 32'h0);         resp("post_rst_read", 32'h0, 4'd0);
    issue(4'h1, 32'd2);         resp("post_rst_sel", 32'h0, 4'd0);
    issue(4'h5, 32'h0);         resp("post_rst_r2", 32'h0, 4'd0);
    issue(4'h3, 32'd4);
    issue(4'h4, 32'hCAFE);
    issue(4'h2, 32'd4);
    issue(4'h6, 32'h0);         resp("post_rst_rw", 32'hCAFE, 4'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
